stereo_channel_scheduler: RTL and testbench
===========================================

STEREO_CHANNEL_SCHEDULER -- requirements
Module: stereo_channel_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18, giving the sample width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of wait cycles per channel (legal range 1..1023).
REQ-003 The block SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports: in_valid  in  1  new stereo pair present; in_left, in_right  in  DATA_W  left/right samples; in_ready  out  1  pair accepted this cycle.
REQ-006 The block SHALL have ports: mux_sel  out  1  0=left, 1=right; proc_start  out  1  start pulse to the shared processor; proc_data  out  DATA_W  selected held sample.
REQ-007 The block SHALL have ports: proc_done  in  1  processor result valid; proc_result  in  DATA_W  processor output.
REQ-008 The block SHALL have ports: out_valid  out  1  pair-complete pulse; out_left, out_right  out  DATA_W  processed pair; timeout_err, overrun_err  out  1  sticky flags.

Function
REQ-009 The FSM SHALL have states IDLE, START_L, WAIT_L, START_R, WAIT_R, OUTPUT.
REQ-010 in_ready SHALL be 1 exactly when state==IDLE.
REQ-011 In IDLE with in_valid=1, the block SHALL capture in_left/in_right into hold registers and go to START_L; otherwise it SHALL stay in IDLE.
REQ-012 START_L and START_R SHALL each last one cycle and assert proc_start=1, then go to WAIT_L/WAIT_R respectively.
REQ-013 mux_sel SHALL be 0 in START_L/WAIT_L and 1 in START_R/WAIT_R/OUTPUT; it SHALL be 0 in IDLE.
REQ-014 proc_data SHALL be the held left sample when mux_sel=0 and the held right sample when mux_sel=1, combinationally from the hold registers.
REQ-015 In WAIT_x with proc_done=1, the block SHALL latch proc_result as the channel result and advance (WAIT_L→START_R, WAIT_R→OUTPUT).
REQ-016 A wait counter SHALL clear on entering WAIT_x and increment each WAIT_x cycle; at the TIMEOUTth wait cycle without proc_done, the block SHALL set the channel result to 0, set timeout_err, and advance as in REQ-015.
REQ-017 If proc_done and timeout coincide, proc_done SHALL win: the result is latched and timeout_err is not set.
REQ-018 proc_done outside WAIT_x SHALL be ignored.
REQ-019 OUTPUT SHALL last one cycle, load out_left/out_right from the channel results, assert out_valid=1, and return to IDLE.
REQ-020 out_left/out_right SHALL hold their values until the next OUTPUT state.
REQ-021 in_valid=1 while in_ready=0 SHALL drop that pair and set overrun_err.
REQ-022 With processor latency N≥1 (done N cycles after start), in_valid accepted at cycle 0 SHALL give out_valid at cycle 2N+3, and in_ready SHALL be 1 again at cycle 2N+4.
REQ-023 The wait counter SHALL be sized to hold TIMEOUT without wrap.

Reset
REQ-024 reset=1 at a clock edge SHALL force state IDLE, hold registers and channel results to 0, out_left/out_right=0, out_valid=0, proc_start=0, mux_sel=0, and timeout_err=overrun_err=0.
REQ-025 reset SHALL take priority over all events, including mid-transaction; any in-flight pair SHALL be discarded and no out_valid SHALL follow.
REQ-026 The error flags SHALL be cleared only by reset.

Structure
REQ-027 The shared package stereo_pkg SHALL hold DATA_W=18 and the FSM state encoding localparams.
REQ-028 The proc_data select SHALL be the team's existing 18-bit two-input select module (multiplexer_2), with a=held left, b=held right, and muxin=mux_sel; no other sub-module SHALL be used.

Verification
REQ-029 in_left=18'h00011, in_right=18'h00022, processor returning input+1 with N=3 -> out_valid at cycle 9, out_left=18'h00012, out_right=18'h00023, in_ready=1 at cycle 10.
REQ-030 Processor never asserts proc_done on left, TIMEOUT=4 -> out_left=0 with the right channel processed normally, and timeout_err=1 until reset.
REQ-031 proc_done arriving on exactly the 4th wait cycle with TIMEOUT=4 -> result latched and timeout_err=0.
REQ-032 Second in_valid pulse while in WAIT_L -> that pair is dropped, overrun_err=1, and the first pair's output is unaffected.
REQ-033 reset asserted during WAIT_R -> next cycle state IDLE, outputs 0, and no out_valid; a following pair then completes normally.
REQ-034 Stray proc_done during IDLE and START_L -> ignored, results unchanged.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared constants and FSM encoding for the stereo channel scheduler.
package stereo_pkg;
  localparam int DATA_W = 18;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START_L = 3'd1;
  localparam logic [2:0] ST_WAIT_L  = 3'd2;
  localparam logic [2:0] ST_START_R = 3'd3;
  localparam logic [2:0] ST_WAIT_R  = 3'd4;
  localparam logic [2:0] ST_OUTPUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_START_L = ST_START_L,
    S_WAIT_L  = ST_WAIT_L,
    S_START_R = ST_START_R,
    S_WAIT_R  = ST_WAIT_R,
    S_OUTPUT  = ST_OUTPUT
  } state_t;
endpackage

// File: rtl/stereo_channel_scheduler_if.sv
// Pair-in, shared-processor and pair-out signals of the stereo scheduler.
interface stereo_channel_scheduler_if #(parameter int DATA_W = 18);
  logic              in_valid;
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_ready;
  logic              mux_sel;
  logic              proc_start;
  logic [DATA_W-1:0] proc_data;
  logic              proc_done;
  logic [DATA_W-1:0] proc_result;
  logic              out_valid;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              timeout_err;
  logic              overrun_err;

  modport slave (
    input  in_valid, in_left, in_right, proc_done, proc_result,
    output in_ready, mux_sel, proc_start, proc_data,
           out_valid, out_left, out_right, timeout_err, overrun_err
  );

  modport master (
    output in_valid, in_left, in_right, proc_done, proc_result,
    input  in_ready, mux_sel, proc_start, proc_data,
           out_valid, out_left, out_right, timeout_err, overrun_err
  );
endinterface

// File: rtl/stereo_channel_scheduler_mux.sv
// Two-input select: muxin=0 gives a, muxin=1 gives b.
module multiplexer_2 #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         muxin,
  output logic [W-1:0] out
);
  assign out = muxin ? b : a;
endmodule

// File: rtl/stereo_channel_scheduler.sv
// Time-shares one processor between the left and right sample of each pair,
// with a per-channel wait timeout and sticky timeout/overrun flags.
module stereo_channel_scheduler #(
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 255
) (
  input logic                       clk,
  input logic                       reset,
  stereo_channel_scheduler_if.slave bus
);
  import stereo_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_res_l, r_res_r;
  logic [DATA_W-1:0] r_out_l, r_out_r;
  logic              r_out_valid, r_proc_start, r_mux_sel;
  logic              r_tmo, r_ovr;

  logic              w_wait, w_tmo_hit, w_adv;
  logic [DATA_W-1:0] w_res, w_proc_data;

  // proc_done beats a coinciding timeout; a timed-out channel reports zero.
  assign w_wait    = (r_state == S_WAIT_L) || (r_state == S_WAIT_R);
  assign w_tmo_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_adv     = w_wait && (bus.proc_done || w_tmo_hit);
  assign w_res     = bus.proc_done ? bus.proc_result : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
      r_res_l      <= '0;
      r_res_r      <= '0;
      r_out_l      <= '0;
      r_out_r      <= '0;
      r_out_valid  <= 1'b0;
      r_proc_start <= 1'b0;
      r_mux_sel    <= 1'b0;
      r_tmo        <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      r_proc_start <= 1'b0;
      r_out_valid  <= 1'b0;
      if (bus.in_valid && r_state != S_IDLE) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_hold_l     <= bus.in_left;
          r_hold_r     <= bus.in_right;
          r_proc_start <= 1'b1;
          r_mux_sel    <= 1'b0;
          r_state      <= S_START_L;
        end
        S_START_L: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_L;
        end
        S_WAIT_L: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_adv) begin
            r_res_l      <= w_res;
            if (!bus.proc_done) r_tmo <= 1'b1;
            r_proc_start <= 1'b1;
            r_mux_sel    <= 1'b1;
            r_state      <= S_START_R;
          end
        end
        S_START_R: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_R;
        end
        S_WAIT_R: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Outputs are registered, so they load on entry to OUTPUT.
          if (w_adv) begin
            r_res_r     <= w_res;
            if (!bus.proc_done) r_tmo <= 1'b1;
            r_out_l     <= r_res_l;
            r_out_r     <= w_res;
            r_out_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          r_mux_sel <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  multiplexer_2 #(.W(DATA_W)) u_mux (
    .a     (r_hold_l),
    .b     (r_hold_r),
    .muxin (r_mux_sel),
    .out   (w_proc_data)
  );

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.mux_sel     = r_mux_sel;
  assign bus.proc_start  = r_proc_start;
  assign bus.proc_data   = w_proc_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_left    = r_out_l;
  assign bus.out_right   = r_out_r;
  assign bus.timeout_err = r_tmo;
  assign bus.overrun_err = r_ovr;
endmodule

// File: tb/tb_stereo_channel_scheduler.sv
// Directed bench: processor model returning data+1 after a set latency.
module tb_stereo_channel_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int   lat_l = 3, lat_r = 3;
  bit   no_left = 1'b0;
  bit   stray = 1'b0;
  int   cd = 0;
  logic [17:0] pd = '0;
  int   c;
  int   nv;

  stereo_channel_scheduler_if #(.DATA_W(18)) bus ();

  stereo_channel_scheduler #(.DATA_W(18), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [17:0] l, input logic [17:0] r);
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int cyc);
    cyc = start;
    while (!bus.out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
  endtask

  // Processor: done N cycles after the cycle proc_start is seen.
  initial begin : proc_model
    bus.proc_done   = 1'b0;
    bus.proc_result = '0;
    forever begin
      @(negedge clk);
      bus.proc_done = 1'b0;
      if (reset) cd = 0;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.proc_done   = 1'b1;
          bus.proc_result = pd + 18'd1;
        end
      end
      if (stray) begin
        bus.proc_done   = 1'b1;
        bus.proc_result = 18'h3FFFF;
      end
      if (!reset && bus.proc_start && !(no_left && !bus.mux_sel)) begin
        cd = bus.mux_sel ? lat_r : lat_l;
        pd = bus.proc_data;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mux_sel", bus.mux_sel, 0);
    chk("rst_proc_start", bus.proc_start, 0);
    chk("rst_out_left", bus.out_left, 0);
    chk("rst_errs", {bus.timeout_err, bus.overrun_err}, 0);
    reset = 1'b0;
    tick();

    // Nominal pair, N=3: out_valid at cycle 9, ready at 10.
    accept(18'h00011, 18'h00022);
    chk("sl_proc_start", bus.proc_start, 1);
    chk("sl_mux_sel", bus.mux_sel, 0);
    chk("sl_proc_data", bus.proc_data, 18'h00011);
    chk("sl_in_ready", bus.in_ready, 0);
    tick();
    chk("wl_proc_start", bus.proc_start, 0);
    wait_out(2, c);
    chk("nom_cycle", c, 9);
    chk("nom_out_left", bus.out_left, 18'h00012);
    chk("nom_out_right", bus.out_right, 18'h00023);
    chk("nom_out_mux", bus.mux_sel, 1);
    tick();
    chk("nom_ready10", bus.in_ready, 1);
    chk("nom_valid_pulse", bus.out_valid, 0);
    chk("nom_hold_left", bus.out_left, 18'h00012);

    // Left never completes: timeout after 4 wait cycles.
    no_left = 1'b1;
    accept(18'h00100, 18'h00200);
    wait_out(1, c);
    no_left = 1'b0;
    chk("tmo_cycle", c, 10);
    chk("tmo_out_left", bus.out_left, 0);
    chk("tmo_out_right", bus.out_right, 18'h00201);
    chk("tmo_flag", bus.timeout_err, 1);
    tick();
    tick();
    chk("tmo_sticky", bus.timeout_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("tmo_cleared", bus.timeout_err, 0);

    // Done on exactly the 4th wait cycle wins over the timeout.
    lat_l = 4;
    lat_r = 1;
    accept(18'h03000, 18'h00005);
    wait_out(1, c);
    chk("edge_cycle", c, 8);
    chk("edge_out_left", bus.out_left, 18'h03001);
    chk("edge_out_right", bus.out_right, 18'h00006);
    chk("edge_no_tmo", bus.timeout_err, 0);
    lat_l = 3;
    lat_r = 3;
    tick();

    // Overrun: second pair during WAIT_L is dropped.
    accept(18'h00AAA, 18'h00BBB);
    tick();
    bus.in_valid = 1'b1;
    bus.in_left  = 18'h00001;
    bus.in_right = 18'h00002;
    tick();
    bus.in_valid = 1'b0;
    chk("ovr_flag", bus.overrun_err, 1);
    wait_out(3, c);
    chk("ovr_cycle", c, 9);
    chk("ovr_out_left", bus.out_left, 18'h00AAB);
    chk("ovr_out_right", bus.out_right, 18'h00BBC);
    tick();
    chk("ovr_ready", bus.in_ready, 1);
    count_valid(6, nv);
    chk("ovr_no_extra", nv, 0);

    // Reset during WAIT_R discards the pair.
    accept(18'h00040, 18'h00050);
    repeat (6) tick();
    chk("mid_mux_r", bus.mux_sel, 1);
    chk("mid_busy", bus.in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_ready", bus.in_ready, 1);
    chk("mid_mux", bus.mux_sel, 0);
    chk("mid_outs", {bus.out_left, bus.out_right}, 0);
    chk("mid_pdata", bus.proc_data, 0);
    chk("mid_ovr", bus.overrun_err, 0);
    count_valid(10, nv);
    chk("mid_no_valid", nv, 0);
    accept(18'h00007, 18'h00008);
    wait_out(1, c);
    chk("post_cycle", c, 9);
    chk("post_outs", {bus.out_left, bus.out_right}, {18'h00008, 18'h00009});
    tick();

    // Stray done in IDLE and START_L; left still times out.
    no_left = 1'b1;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_idle_ready", bus.in_ready, 1);
    chk("stray_idle_valid", bus.out_valid, 0);
    accept(18'h00123, 18'h00456);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("stray_sl_mux", bus.mux_sel, 0);
    wait_out(2, c);
    no_left = 1'b0;
    chk("stray_cycle", c, 10);
    chk("stray_out_left", bus.out_left, 0);
    chk("stray_out_right", bus.out_right, 18'h00457);
    chk("stray_tmo", bus.timeout_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
